// File: rtl/kmap_ctrl_pkg.sv
// Shared types and constants for the parity-evaluator arbiter.
// KMAP_SWEEP_EN adds the SWEEP self-test state.
package kmap_ctrl_pkg;

    localparam logic [15:0] KMAP_TT   = 16'h6996;
    localparam int          SWEEP_LEN = 16;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        RESP
`ifdef KMAP_SWEEP_EN
        ,
        SWEEP
`endif
    } state_t;

endpackage

// File: rtl/kmap_parity_eval.sv
// Combinational 4-input odd-parity evaluator; the sweep checks it against KMAP_TT.
module kmap_parity_eval (
    input  logic [3:0] x,
    output logic       y
);

    assign y = ^x;

endmodule

// File: rtl/kmap_eval_arbiter.sv
// Round-robin arbiter sharing one parity evaluator among NREQ requesters.
// Optional self-test sweep enabled by defining KMAP_SWEEP_EN.
module kmap_eval_arbiter
    import kmap_ctrl_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 areset,
    input  logic [NREQ-1:0]      req,
    input  logic [4*NREQ-1:0]    vec,
    output logic [NREQ-1:0]      gnt,
    output logic                 rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic                 rsp_out,
    output logic                 busy,
    input  logic                 sweep_start,
    output logic                 sweep_done,
    output logic                 sweep_fail
);

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] lat_id;
    logic [3:0]     lat_vec;
    logic [IDW-1:0] nxt_ptr;
    logic [IDW-1:0] arb_ptr;
    logic [IDW-1:0] win;
    logic [IDW-1:0] cand;
    logic           any_req;
    logic [3:0]     eval_in;
    logic           eval_out;

    // Back-to-back arbitration in RESP must already see the advanced pointer.
    assign nxt_ptr = (lat_id == IDW'(NREQ - 1)) ? '0 : lat_id + 1'b1;
    assign arb_ptr = (state == RESP) ? nxt_ptr : ptr;
    assign any_req = |req;

    // NOTE: every variable gets a default before the loop, so no latch is inferred.
    always_comb begin
        win  = '0;
        cand = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IDW'((int'(arb_ptr) + NREQ - 1 - i) % NREQ);
            if (req[cand]) win = cand;
        end
    end

`ifdef KMAP_SWEEP_EN
    logic [3:0] sweep_idx;
    assign eval_in = (state == SWEEP) ? sweep_idx : lat_vec;
`else
    logic unused_sweep_start;
    assign unused_sweep_start = sweep_start;
    assign eval_in    = lat_vec;
    assign sweep_done = 1'b0;
    assign sweep_fail = 1'b0;
`endif

    kmap_parity_eval u_eval (
        .x (eval_in),
        .y (eval_out)
    );

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state     <= IDLE;
            ptr       <= '0;
            lat_id    <= '0;
            lat_vec   <= '0;
            gnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_out   <= 1'b0;
            busy      <= 1'b0;
`ifdef KMAP_SWEEP_EN
            sweep_idx  <= '0;
            sweep_done <= 1'b0;
            sweep_fail <= 1'b0;
`endif
        end else begin
            gnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_out   <= 1'b0;
`ifdef KMAP_SWEEP_EN
            sweep_done <= 1'b0;
`endif
            case (state)
                IDLE: begin
`ifdef KMAP_SWEEP_EN
                    if (sweep_start) begin
                        state      <= SWEEP;
                        sweep_idx  <= '0;
                        sweep_fail <= 1'b0;
                        busy       <= 1'b1;
                    end else
`endif
                    if (any_req) begin
                        state   <= GRANT;
                        gnt     <= NREQ'(1) << win;
                        lat_id  <= win;
                        lat_vec <= vec[4*int'(win) +: 4];
                        busy    <= 1'b1;
                    end
                end
                GRANT: begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_id    <= lat_id;
                    rsp_out   <= eval_out;
                end
                RESP: begin
                    ptr <= nxt_ptr;
                    if (any_req) begin
                        state   <= GRANT;
                        gnt     <= NREQ'(1) << win;
                        lat_id  <= win;
                        lat_vec <= vec[4*int'(win) +: 4];
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
`ifdef KMAP_SWEEP_EN
                SWEEP: begin
                    if (eval_out != KMAP_TT[sweep_idx]) sweep_fail <= 1'b1;
                    if (sweep_idx == 4'(SWEEP_LEN - 1)) begin
                        state      <= IDLE;
                        sweep_done <= 1'b1;
                        busy       <= 1'b0;
                    end else begin
                        sweep_idx <= sweep_idx + 1'b1;
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kmap_eval_arbiter.sv
// Directed scoreboard bench for kmap_eval_arbiter; responses checked by a separate monitor.
module tb_kmap_eval_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                areset;
    logic [NREQ-1:0]     req;
    logic [4*NREQ-1:0]   vec;
    logic [NREQ-1:0]     gnt;
    logic                rsp_valid;
    logic [IDW-1:0]      rsp_id;
    logic                rsp_out;
    logic                busy;
    logic                sweep_start;
    logic                sweep_done;
    logic                sweep_fail;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic           out;
    } rsp_t;

    rsp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    kmap_eval_arbiter #(.NREQ(NREQ)) dut (
        .clk         (clk),
        .areset      (areset),
        .req         (req),
        .vec         (vec),
        .gnt         (gnt),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_out     (rsp_out),
        .busy        (busy),
        .sweep_start (sweep_start),
        .sweep_done  (sweep_done),
        .sweep_fail  (sweep_fail)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic push(input int id, input logic out);
        rsp_t e;
        e.id  = IDW'(id);
        e.out = out;
        exp_q.push_back(e);
    endtask

    // Monitor: pops one expectation per response strobe, checks idle zeros otherwise.
    always @(negedge clk) begin
        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                check("rsp_id", 32'(rsp_id), 32'(e.id));
                check("rsp_out", 32'(rsp_out), 32'(e.out));
            end
        end else begin
            check("idle_rsp_zero", {30'd0, rsp_id, rsp_out}, 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Lane parities: L0=1111->0, L1=1000->1, L2=0111->1, L3=0011->0.
        areset      = 1'b1;
        req         = '0;
        sweep_start = 1'b0;
        vec         = {4'b0011, 4'b0111, 4'b1000, 4'b1111};
        step(); step();
        areset = 1'b0;
        step();
        check("reset_gnt", 32'(gnt), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_sweep", {30'd0, sweep_done, sweep_fail}, 32'd0);

        // Single request from requester 2; req dropped while in GRANT.
        req = 4'b0100;
        push(2, 1'b1);
        step();
        check("single_gnt", 32'(gnt), 32'b0100);
        check("single_busy", 32'(busy), 32'd1);
        req = '0;
        step();
        check("resp_gnt_zero", 32'(gnt), 32'd0);
        step();
        check("idle_busy", 32'(busy), 32'd0);

        // ptr is now 3: requesters 0 and 3 contend, 3 wins, then 0 via wrap.
        req = 4'b1001;
        push(3, 1'b0);
        push(0, 1'b0);
        step();
        check("ptr3_gnt", 32'(gnt), 32'b1000);
        req = 4'b0001;
        step();
        step();
        check("wrap_gnt", 32'(gnt), 32'b0001);
        req = '0;
        step(); step();

        // All four held continuously from reset.
        areset = 1'b1;
        step();
        areset = 1'b0;
        req = 4'b1111;
        push(0, 1'b0); push(1, 1'b1); push(2, 1'b1); push(3, 1'b0); push(0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("rr_gnt%0d", k), 32'(gnt), 32'(4'b0001 << (k % 4)));
            if (k == 4) req = '0;
            step();
        end
        step();
        check("rr_idle_busy", 32'(busy), 32'd0);

        // Reset during GRANT discards the in-flight response; ptr returns to 0.
        req = 4'b0001;
        step();
        check("pre_rst_gnt", 32'(gnt), 32'b0001);
        #2 areset = 1'b1;
        #1;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        step();
        step();
        areset = 1'b0;
        req = 4'b0011;
        push(0, 1'b0);
        step();
        check("post_rst_gnt", 32'(gnt), 32'b0001);
        req = 4'b0010;
        push(1, 1'b1);
        step();
        step();
        check("post_rst_gnt2", 32'(gnt), 32'b0010);
        req = '0;
        step(); step();

`ifdef KMAP_SWEEP_EN
        // Sweep takes precedence over a simultaneous request.
        sweep_start = 1'b1;
        req = 4'b0010;
        push(1, 1'b1);
        for (int i = 0; i < 16; i++) begin
            step();
            sweep_start = 1'b0;
            check($sformatf("sweep_busy%0d", i), 32'(busy), 32'd1);
            check($sformatf("sweep_gnt%0d", i), 32'(gnt), 32'd0);
            check($sformatf("sweep_done_low%0d", i), 32'(sweep_done), 32'd0);
        end
        step();
        check("sweep_done", 32'(sweep_done), 32'd1);
        check("sweep_fail", 32'(sweep_fail), 32'd0);
        check("sweep_end_busy", 32'(busy), 32'd0);
        step();
        check("sweep_after_gnt", 32'(gnt), 32'b0010);
        check("sweep_done_pulse", 32'(sweep_done), 32'd0);
        req = '0;
        step(); step();
`else
        sweep_start = 1'b1;
        step();
        sweep_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("nosweep_busy%0d", i), 32'(busy), 32'd0);
            check($sformatf("nosweep_flags%0d", i), {30'd0, sweep_done, sweep_fail}, 32'd0);
            step();
        end
`endif

        step();
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
